pellet_scan_ctrl: RTL
=====================

Name: pellet_scan_ctrl

Overview:
- Per-frame scheduler that owns the eaten/visible state of every maze pellet.
- One shared collision comparator is time-multiplexed across all pellets, one pellet per clock, once per frame.
- Maintains score, pellets remaining and level-clear status.
- Serves a registered lookup port to the renderer, which asks "is pellet N eaten?".

Parameters:
- COLS, 16, pellet grid columns
- ROWS, 12, pellet grid rows
- X0, 40, pixel X of column 0
- Y0, 40, pixel Y of row 0
- PITCH, 32, pixel spacing between adjacent pellets (X and Y)
- HIT_R, 6, collision half-window in pixels
- DOT_POINTS, 10, score added per normal pellet
- POWER_POINTS, 50, score added per power pellet (used only with the optional feature)

Ports:
- Clk, in, 1, system clock
- Reset, in, 1, synchronous, active-high
- frame_start, in, 1, one-cycle pulse at start of vertical blank
- level_reset, in, 1, one-cycle pulse: restore all pellets
- pacX, in, 10, Pac-Man centre X
- pacY, in, 10, Pac-Man centre Y
- q_index, in, IDX_W, renderer query index (IDX_W = clog2(COLS*ROWS))
- q_eaten, out, 1, eaten bit for q_index; 1-cycle latency
- busy, out, 1, scan in progress
- eat_pulse, out, 1, one-cycle pulse when a pellet is newly eaten
- eat_index, out, IDX_W, index of that pellet; valid with eat_pulse
- power_pulse, out, 1, power pellet eaten (optional feature)
- score, out, 16, accumulated score
- dots_left, out, IDX_W+1, pellets not yet eaten
- level_clear, out, 1, all pellets eaten

Behaviour:
Interface and reset
- Clocking: Clk; reset Reset, synchronous, active-high.
- Reset values: all eaten bits 0; score 0; dots_left = COLS*ROWS; busy 0; eat_pulse 0; power_pulse 0; eat_index 0; level_clear 0; q_eaten 0; FSM in IDLE.
- Reset in the middle of a scan aborts the scan immediately.

Geometry and collision
- Pellet index i = r*COLS + c.
- Pellet position: X = X0 + c*PITCH, Y = Y0 + r*PITCH, computed from a column/row counter pair, not a multiplier.
- Collision condition: |dotX - pacX| <= HIT_R AND |dotY - pacY| <= HIT_R.
- Evaluate the collision in 11-bit signed arithmetic; no unsigned underflow when pacX < HIT_R.

FSM states: IDLE, SCAN, CLEAR
- IDLE: frame_start -> latch pacX/pacY, index := 0, go to SCAN.
- SCAN (busy=1):
  - Each cycle, evaluate pellet at index using the latched position only.
  - On a hit with eaten[index]=0: set eaten[index]; next cycle assert eat_pulse with eat_index=index; dots_left -= 1; score += DOT_POINTS, saturating at 0xFFFF.
  - A hit on an already-eaten pellet does nothing.
  - Last index (COLS*ROWS-1) -> IDLE.
  - A scan therefore takes exactly COLS*ROWS cycles. busy is high from the cycle after frame_start through the last evaluation cycle.
  - frame_start during SCAN is ignored.
- level_reset, from any state -> CLEAR. Priority over frame_start in the same cycle.
- CLEAR (one cycle, busy=1): all eaten bits := 0; dots_left := COLS*ROWS; level_clear := 0; score unchanged; then go to IDLE. Any eat_pulse still pending is suppressed.

Status and lookup
- level_clear: set in the same cycle dots_left is written to 0; held until CLEAR or Reset. Scans still run while level_clear=1 but find nothing.
- q_eaten: registered eaten[q_index], available one cycle after q_index is presented. It is independent of the FSM and reflects writes of the previous cycle. q_index >= COLS*ROWS returns 1.

Optional Feature:
- Macro: PELLET_POWER_EN
- With the macro: indices 0, COLS-1, (ROWS-1)*COLS and COLS*ROWS-1 are power pellets. Eating one adds POWER_POINTS instead of DOT_POINTS and asserts power_pulse together with eat_pulse.
- Without the macro: all pellets are normal and power_pulse is tied 0.

Decomposition:
- Package pellet_pkg holds:
  - COLS/ROWS defaults, IDX_W, NUM_DOTS
  - the state typedef (IDLE/SCAN/CLEAR)
  - the points constants
  - a function is_power(index)
- Natural sub-module: pellet_hit_cmp, the combinational signed window comparator (dot vs pac, HIT_R). Instantiated once and shared by the scan.

Test Plan:
- Reset, then query q_index=17 -> q_eaten=0; dots_left=192; score=0; level_clear=0.
- Pac at (74,70), frame_start -> pellet 17 (X=72,Y=72) eaten; exactly one eat_pulse with eat_index=17; score=10; dots_left=191; busy high for 192 cycles. Repeat frame -> no eat_pulse; score stays 10.
- Pac at (3,3) -> no hit on pellet 0 (X=40,Y=40) and no underflow false hit. Pac at (46,34) -> pellet 0 eaten, since the window is inclusive at 6.
- Force 191 pellets eaten, then hit the last one -> dots_left=0 and level_clear=1 in that cycle. level_reset with frame_start in the same cycle -> CLEAR wins; dots_left=192; score retained; no scan started.
- Reset asserted mid-scan at index 100 -> busy=0 next cycle; all bits 0; score=0.
- With PELLET_POWER_EN, pac at (40,40) -> power_pulse with eat_pulse; score +50. Without the macro -> power_pulse stays 0; score +10.

Source files
------------

// File: rtl/pellet_pkg.sv
// Shared constants, FSM state type and power-pellet map for the pellet scanner.
// PELLET_POWER_EN enables the four corner power pellets.
package pellet_pkg;

    localparam int COLS         = 16;
    localparam int ROWS         = 12;
    localparam int NUM_DOTS     = COLS * ROWS;
    localparam int IDX_W        = $clog2(NUM_DOTS);
    localparam int COORD_W      = 10;

    localparam int DOT_POINTS   = 10;
    localparam int POWER_POINTS = 50;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CLEAR = 2'd2
    } state_e;

    // Corner pellets are the power pellets.
    function automatic logic is_power(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(0))
            || (idx == IDX_W'(COLS - 1))
            || (idx == IDX_W'((ROWS - 1) * COLS))
            || (idx == IDX_W'(NUM_DOTS - 1));
    endfunction

endpackage

// File: rtl/pellet_scan_ctrl_if.sv
// Game-logic / renderer side of the pellet scanner.
// master = frame timing, Pac-Man position and renderer queries; slave = scanner.
interface pellet_scan_ctrl_if;
    import pellet_pkg::*;

    logic                 frame_start;
    logic                 level_reset;
    logic [COORD_W-1:0]   pacX;
    logic [COORD_W-1:0]   pacY;
    logic [IDX_W-1:0]     q_index;
    logic                 q_eaten;
    logic                 busy;
    logic                 eat_pulse;
    logic [IDX_W-1:0]     eat_index;
    logic                 power_pulse;
    logic [15:0]          score;
    logic [IDX_W:0]       dots_left;
    logic                 level_clear;

    modport master (
        output frame_start, level_reset, pacX, pacY, q_index,
        input  q_eaten, busy, eat_pulse, eat_index, power_pulse,
               score, dots_left, level_clear
    );

    modport slave (
        input  frame_start, level_reset, pacX, pacY, q_index,
        output q_eaten, busy, eat_pulse, eat_index, power_pulse,
               score, dots_left, level_clear
    );

endinterface

// File: rtl/pellet_hit_cmp.sv
// Combinational collision window: |dot - pac| <= HIT_R on both axes.
// Differences are taken in 11-bit signed so a small pac coordinate cannot wrap.
module pellet_hit_cmp
    import pellet_pkg::*;
#(
    parameter int HIT_R = 6
) (
    input  logic [COORD_W-1:0] dot_x_i,
    input  logic [COORD_W-1:0] dot_y_i,
    input  logic [COORD_W-1:0] pac_x_i,
    input  logic [COORD_W-1:0] pac_y_i,
    output logic               hit_o
);

    localparam logic signed [COORD_W:0] R = (COORD_W+1)'(HIT_R);

    logic signed [COORD_W:0] dx, dy, adx, ady;

    assign dx  = $signed({1'b0, dot_x_i}) - $signed({1'b0, pac_x_i});
    assign dy  = $signed({1'b0, dot_y_i}) - $signed({1'b0, pac_y_i});
    assign adx = dx[COORD_W] ? -dx : dx;
    assign ady = dy[COORD_W] ? -dy : dy;

    assign hit_o = (adx <= R) && (ady <= R);

endmodule

// File: rtl/pellet_scan_ctrl.sv
// Per-frame pellet scanner: walks every pellet once per frame through one
// shared collision comparator, owns the eaten bits, score, dots left and
// level-clear status, and answers registered renderer lookups.
// Optional: PELLET_POWER_EN makes the four corner pellets power pellets.
module pellet_scan_ctrl
    import pellet_pkg::*;
#(
    parameter int X0    = 40,
    parameter int Y0    = 40,
    parameter int PITCH = 32,
    parameter int HIT_R = 6
) (
    input  logic               Clk,
    input  logic               Reset,
    pellet_scan_ctrl_if.slave  bus
);

    localparam int COL_W = $clog2(COLS);

    state_e               state_q, state_d;
    logic                 latch, step, clr;

    logic [COORD_W-1:0]   pac_x_q, pac_y_q;
    logic [COORD_W-1:0]   dot_x_q, dot_y_q;
    logic [COL_W-1:0]     col_q;
    logic [IDX_W-1:0]     idx_q;

    logic [NUM_DOTS-1:0]  eaten_q;
    logic [15:0]          score_q, score_d;
    logic [IDX_W:0]       dots_q;
    logic                 lc_q;
    logic                 eat_pulse_q;
    logic [IDX_W-1:0]     eat_index_q;
    logic                 q_eaten_q;

    logic                 hit, eat, pwr;
    logic [15:0]          pts;
    logic [16:0]          sum;

    pellet_hit_cmp #(.HIT_R(HIT_R)) u_cmp (
        .dot_x_i (dot_x_q),
        .dot_y_i (dot_y_q),
        .pac_x_i (pac_x_q),
        .pac_y_i (pac_y_q),
        .hit_o   (hit)
    );

    // A hit only counts on the first visit; level_reset already forced CLEAR.
    assign eat = step && hit && !eaten_q[idx_q];

`ifdef PELLET_POWER_EN
    assign pwr = is_power(idx_q);
`else
    assign pwr = 1'b0;
`endif
    assign pts     = pwr ? 16'(POWER_POINTS) : 16'(DOT_POINTS);
    assign sum     = {1'b0, score_q} + {1'b0, pts};
    assign score_d = sum[16] ? 16'hFFFF : sum[15:0];

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and per-cycle control strobes; level_reset wins everywhere.
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        step    = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.level_reset) begin
                    state_d = CLEAR;
                end else if (bus.frame_start) begin
                    latch   = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (bus.level_reset) begin
                    state_d = CLEAR;
                end else begin
                    step = 1'b1;
                    if (idx_q == IDX_W'(NUM_DOTS - 1)) state_d = IDLE;
                end
            end
            CLEAR: begin
                clr     = 1'b1;
                state_d = bus.level_reset ? CLEAR : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan position: index plus column counter and incrementally stepped pixel coords.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pac_x_q <= '0;
            pac_y_q <= '0;
            dot_x_q <= COORD_W'(X0);
            dot_y_q <= COORD_W'(Y0);
            col_q   <= '0;
            idx_q   <= '0;
        end else if (latch) begin
            pac_x_q <= bus.pacX;
            pac_y_q <= bus.pacY;
            dot_x_q <= COORD_W'(X0);
            dot_y_q <= COORD_W'(Y0);
            col_q   <= '0;
            idx_q   <= '0;
        end else if (step) begin
            idx_q <= idx_q + 1'b1;
            if (col_q == COL_W'(COLS - 1)) begin
                col_q   <= '0;
                dot_x_q <= COORD_W'(X0);
                dot_y_q <= dot_y_q + COORD_W'(PITCH);
            end else begin
                col_q   <= col_q + 1'b1;
                dot_x_q <= dot_x_q + COORD_W'(PITCH);
            end
        end
    end

    // Pellet state, score and status; an eat is reported the cycle after evaluation.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            eaten_q     <= '0;
            score_q     <= '0;
            dots_q      <= (IDX_W+1)'(NUM_DOTS);
            lc_q        <= 1'b0;
            eat_pulse_q <= 1'b0;
            eat_index_q <= '0;
        end else begin
            eat_pulse_q <= 1'b0;
            if (clr) begin
                eaten_q <= '0;
                dots_q  <= (IDX_W+1)'(NUM_DOTS);
                lc_q    <= 1'b0;
            end else if (eat) begin
                eaten_q[idx_q] <= 1'b1;
                eat_pulse_q    <= 1'b1;
                eat_index_q    <= idx_q;
                dots_q         <= dots_q - 1'b1;
                score_q        <= score_d;
                if (dots_q == (IDX_W+1)'(1)) lc_q <= 1'b1;
            end
        end
    end

`ifdef PELLET_POWER_EN
    logic power_pulse_q;

    // Power flag rides alongside the eat pulse.
    always_ff @(posedge Clk) begin
        if (Reset)    power_pulse_q <= 1'b0;
        else          power_pulse_q <= eat && !clr && pwr;
    end
    assign bus.power_pulse = power_pulse_q;
`else
    assign bus.power_pulse = 1'b0;
`endif

    // Renderer lookup, independent of the scan; out-of-range reads as eaten.
    always_ff @(posedge Clk) begin
        if (Reset)
            q_eaten_q <= 1'b0;
        else if (bus.q_index >= IDX_W'(NUM_DOTS))
            q_eaten_q <= 1'b1;
        else
            q_eaten_q <= eaten_q[bus.q_index];
    end

    assign bus.q_eaten     = q_eaten_q;
    assign bus.busy        = (state_q == SCAN) || (state_q == CLEAR);
    assign bus.eat_pulse   = eat_pulse_q;
    assign bus.eat_index   = eat_index_q;
    assign bus.score       = score_q;
    assign bus.dots_left   = dots_q;
    assign bus.level_clear = lc_q;

endmodule
